// File: rtl/count_signals_expander_pkg.sv
// Shared types and sizing helpers for the count-to-signals expander.
// State encodings are fixed so they stay stable in waveforms and debug taps.
package count_signals_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_COUNT_DEF = 4;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/count_signals_expander_therm.sv
// Combinational count -> thermometer decode; counts above MAX_COUNT give all zeros.
module count_to_thermometer
  import count_signals_pkg::*;
#(
  parameter int MAX_COUNT = MAX_COUNT_DEF,
  parameter int COUNT_W   = 3
) (
  input  logic [COUNT_W-1:0]   count,
  output logic [MAX_COUNT-1:0] therm
);

  logic legal;

  assign legal = (int'(count) <= MAX_COUNT);

  always_comb begin
    therm = '0;
    for (int i = 0; i < MAX_COUNT; i++) begin
      therm[i] = legal && (int'(count) > i);
    end
  end

endmodule

// File: rtl/count_signals_expander.sv
// Expands an accepted count into a held thermometer and a train of pulses ending in done.
// Outputs are decoded from registered state only; in_ready depends on state alone.
module count_signals_expander
  import count_signals_pkg::*;
#(
  parameter int MAX_COUNT = MAX_COUNT_DEF,
  parameter int COUNT_W   = 3,
  parameter int PULSE_GAP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [COUNT_W-1:0]   in_count,
  output logic                 in_ready,
  output logic [MAX_COUNT-1:0] lanes,
  output logic                 pulse,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int REM_W = cnt_w(MAX_COUNT);
  localparam int GAP_W = cnt_w(PULSE_GAP);

  state_t             state;
  state_t             state_n;
  logic [REM_W-1:0]   remaining;
  logic [GAP_W-1:0]   gap_cnt;
  logic [MAX_COUNT-1:0] therm;
  logic               accept;
  logic               illegal;

  count_to_thermometer #(
    .MAX_COUNT (MAX_COUNT),
    .COUNT_W   (COUNT_W)
  ) u_therm (
    .count (in_count),
    .therm (therm)
  );

  assign accept  = in_valid && (state == IDLE);
  assign illegal = (int'(in_count) > MAX_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept && !illegal) begin
          state_n = (in_count == '0) ? DONE : PULSE;
        end
      end
      PULSE: begin
        if (remaining == REM_W'(1)) begin
          state_n = DONE;
        end else if (PULSE_GAP == 0) begin
          state_n = PULSE;
        end else begin
          state_n = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_n = PULSE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    pulse    = (state == PULSE);
    done     = (state == DONE);
    busy     = (state != IDLE);
  end

  // An illegal count only raises err; lanes keep the last legal expansion.
  always_ff @(posedge clk) begin
    if (reset) begin
      lanes     <= '0;
      err       <= 1'b0;
      remaining <= '0;
      gap_cnt   <= '0;
    end else begin
      err <= accept && illegal;
      if (accept && !illegal) begin
        lanes     <= therm;
        remaining <= REM_W'(in_count);
      end
      if (state == PULSE) begin
        remaining <= remaining - REM_W'(1);
        gap_cnt   <= GAP_W'(PULSE_GAP);
      end
      if (state == GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_count_signals_expander.sv
// Directed bench: instance 1 uses PULSE_GAP=1, instance 0 uses PULSE_GAP=0.
module tb_count_signals_expander;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid [2];
  logic [2:0] in_count [2];
  logic       in_ready [2];
  logic [3:0] lanes    [2];
  logic       pulse    [2];
  logic       busy     [2];
  logic       done     [2];
  logic       err      [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  count_signals_expander #(.MAX_COUNT(4), .COUNT_W(3), .PULSE_GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_count(in_count[0]),
    .in_ready(in_ready[0]), .lanes(lanes[0]), .pulse(pulse[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0])
  );

  count_signals_expander #(.MAX_COUNT(4), .COUNT_W(3), .PULSE_GAP(1)) u_g1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_count(in_count[1]),
    .in_ready(in_ready[1]), .lanes(lanes[1]), .pulse(pulse[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int         sel;
    logic [2:0] cnt;
    int         pmask;
    int         done_at;
    int         err_cyc;
    int         ready_at;
    logic [3:0] lanes1;
    int         busy_cyc;
  } vec_t;

  // One transaction: offer cnt for exactly one accepting edge, then observe 12 cycles.
  task automatic run_expand(input int sel, input logic [2:0] cnt,
                            output int pmask, output int done_at, output int done_cnt,
                            output int err_cyc, output int ready_at,
                            output logic [3:0] lanes1, output int busy_cyc);
    pmask = 0; done_at = 0; done_cnt = 0; err_cyc = 0; ready_at = 0; busy_cyc = 0;
    lanes1 = '0;
    @(negedge clk);
    in_valid[sel] = 1'b1;
    in_count[sel] = cnt;
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 1) lanes1 = lanes[sel];
      if (pulse[sel]) pmask |= (1 << j);
      if (done[sel]) begin
        done_cnt++;
        if (done_at == 0) done_at = j;
      end
      if (err[sel]) err_cyc++;
      if (busy[sel]) busy_cyc++;
      if (in_ready[sel] && ready_at == 0) ready_at = j;
    end
  endtask

  vec_t vecs [13];

  initial begin
    int         pm, da, dc, ec, ra, bc, pre_p, post_p, post_d;
    logic [3:0] l1;
    int         dmask, k;

    // sel, cnt, pulse mask (bit j = cycle k+j), done_at, err cycles, ready_at, lanes, busy cycles
    vecs[0]  = '{1, 3'd3, 32'h2A, 6, 0, 7, 4'b0111, 6};
    vecs[1]  = '{0, 3'd4, 32'h1E, 5, 0, 6, 4'b1111, 5};
    vecs[2]  = '{1, 3'd0, 0,      1, 0, 2, 4'b0000, 1};
    vecs[3]  = '{0, 3'd0, 0,      1, 0, 2, 4'b0000, 1};
    vecs[4]  = '{1, 3'd2, 32'h0A, 4, 0, 5, 4'b0011, 4};
    vecs[5]  = '{1, 3'd5, 0,      0, 1, 1, 4'b0011, 0};
    vecs[6]  = '{1, 3'd7, 0,      0, 1, 1, 4'b0011, 0};
    vecs[7]  = '{1, 3'd1, 32'h02, 2, 0, 3, 4'b0001, 2};
    vecs[8]  = '{0, 3'd2, 32'h06, 3, 0, 4, 4'b0011, 3};
    vecs[9]  = '{0, 3'd5, 0,      0, 1, 1, 4'b0011, 0};
    vecs[10] = '{0, 3'd1, 32'h02, 2, 0, 3, 4'b0001, 2};
    vecs[11] = '{1, 3'd4, 32'hAA, 8, 0, 9, 4'b1111, 8};
    vecs[12] = '{0, 3'd7, 0,      0, 1, 1, 4'b0001, 0};

    // Reset held two cycles with a legal count offered on both instances.
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b1;
      in_count[s] = 3'd3;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_lanes%0d", s), int'(lanes[s]), 0);
      chk($sformatf("rst_pulse%0d", s), int'(pulse[s]), 0);
      chk($sformatf("rst_busy%0d", s),  int'(busy[s]),  0);
      chk($sformatf("rst_done%0d", s),  int'(done[s]),  0);
      chk($sformatf("rst_err%0d", s),   int'(err[s]),   0);
    end
    reset = 1'b0;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("post_rst_ready%0d", s), int'(in_ready[s]), 1);
      chk($sformatf("post_rst_busy%0d", s),  int'(busy[s]),     0);
    end

    foreach (vecs[i]) begin
      run_expand(vecs[i].sel, vecs[i].cnt, pm, da, dc, ec, ra, l1, bc);
      chk($sformatf("v%0d_pulses", i),   pm, vecs[i].pmask);
      chk($sformatf("v%0d_done_at", i),  da, vecs[i].done_at);
      chk($sformatf("v%0d_done_cnt", i), dc, (vecs[i].done_at != 0) ? 1 : 0);
      chk($sformatf("v%0d_err", i),      ec, vecs[i].err_cyc);
      chk($sformatf("v%0d_ready_at", i), ra, vecs[i].ready_at);
      chk($sformatf("v%0d_lanes", i),    int'(l1), int'(vecs[i].lanes1));
      chk($sformatf("v%0d_busy", i),     bc, vecs[i].busy_cyc);
    end

    // Reset during the 2nd pulse of a 4-count on the back-to-back instance.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_count[0] = 3'd4;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    pre_p = 0;
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk);
      pre_p += int'(pulse[0]);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    post_p = 0;
    post_d = 0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 1) begin
        chk("midrst_lanes", int'(lanes[0]), 0);
        chk("midrst_ready", int'(in_ready[0]), 1);
      end
      post_p += int'(pulse[0]);
      post_d += int'(done[0]);
    end
    chk("midrst_pre_pulses", pre_p, 2);
    chk("midrst_post_pulses", post_p, 0);
    chk("midrst_post_done", post_d, 0);
    run_expand(0, 3'd2, pm, da, dc, ec, ra, l1, bc);
    chk("after_rst_pulses", pm, 32'h06);
    chk("after_rst_done_at", da, 3);
    chk("after_rst_lanes", int'(l1), 4'b0011);

    // Back-to-back on the gapped instance: count 2 then 1 with in_valid held.
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_count[1] = 3'd2;
    @(posedge clk);
    #1;
    in_count[1] = 3'd1;
    pm = 0;
    dmask = 0;
    k = 0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j == 1) chk("b2b_lanes_first", int'(lanes[1]), 4'b0011);
      if (pulse[1]) pm |= (1 << j);
      if (done[1]) dmask |= (1 << j);
      if (in_valid[1] && in_ready[1] && j > 1 && k == 0) k = j;
      @(posedge clk);
      #1;
      if (k != 0) in_valid[1] = 1'b0;
    end
    chk("b2b_second_accept_cycle", k, 5);
    chk("b2b_pulses", pm, 32'h4A);
    chk("b2b_dones", dmask, 32'h90);
    chk("b2b_lanes_last", int'(lanes[1]), 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
